// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Purpose  : Bundles the Writeback, long-latency and register-file port signals.
// Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int FIFO_DEPTH = 2
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             w_we;
    logic [4:0]       w_dest;
    logic [31:0]      w_data;
    logic             w_hold;
    logic             ll_valid;
    logic             ll_ready;
    logic [4:0]       ll_dest;
    logic [31:0]      ll_data;
    logic             ll_flush;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      ll_pend_mask;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  w_we, w_dest, w_data, ll_valid, ll_dest, ll_data, ll_flush,
        output w_hold, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pend_mask, fifo_count
    );

    modport master (
        output w_we, w_dest, w_data, ll_valid, ll_dest, ll_data, ll_flush,
        input  w_hold, ll_ready, rf_we, rf_waddr, rf_wdata, ll_pend_mask, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the RF write port between Writeback and a queued LL unit.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [4:0]            dest_q [FIFO_DEPTH];
    logic [4:0]            dest_d [FIFO_DEPTH];
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [31:0]           data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic w_empty, w_full, w_head_vld, w_hold, w_grant, w_kill_en, w_pop, w_push;
    logic [31:0] w_mask;

    always_comb begin
        w_empty    = (count_q == '0);
        w_full     = (count_q == CNT_W'(FIFO_DEPTH));
        w_head_vld = vld_q[rd_ptr_q] && !w_empty;
        w_hold     = !w_empty && (wait_cnt_q >= WAIT_W'(MAX_WAIT));
        w_grant    = bus.w_we && !w_hold;
        w_kill_en  = w_grant && (bus.w_dest != 5'd0);
        // A killed head leaves regardless of who owns the port.
        w_pop      = !w_empty && (!w_head_vld || !w_grant);
        w_push     = bus.ll_valid && !w_full;
    end

    assign bus.w_hold     = w_hold;
    assign bus.ll_ready   = !w_full;
    assign bus.fifo_count = count_q;

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        if (!rst) begin
            if (w_grant) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.w_dest;
                bus.rf_wdata = bus.w_data;
            end else if (w_head_vld) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = dest_q[rd_ptr_q];
                bus.rf_wdata = data_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        w_mask = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i]) begin
                w_mask[dest_q[i]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end

    assign bus.ll_pend_mask = w_mask;

    always_comb begin
        vld_d      = vld_q;
        dest_d     = dest_q;
        data_d     = data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        wait_cnt_d = wait_cnt_q;

        // The Writeback result is younger than anything queued: older LL
        // results to the same register must never reach the RF.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_kill_en && (dest_q[i] == bus.w_dest)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (w_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (w_push) begin
            vld_d[wr_ptr_q]  = (bus.ll_dest != 5'd0) &&
                               !(w_kill_en && (bus.ll_dest == bus.w_dest));
            dest_d[wr_ptr_q] = bus.ll_dest;
            data_d[wr_ptr_q] = bus.ll_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        if (w_empty || (w_head_vld && w_pop)) begin
            wait_cnt_d = '0;
        end else if (w_head_vld && w_grant && (wait_cnt_q < WAIT_W'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (bus.ll_flush) begin
            vld_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Payload needs no reset; the valid bits and count gate every use of it.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed and randomized bench for wb_port_arbiter with a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int MAXW  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        bit        vld;
        bit [4:0]  dest;
        bit [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ent_t        mq[$];
    int          mwait;
    logic [31:0] rf_shadow [32];

    logic          e_grant, e_hold, e_ready, e_rf_we;
    logic [4:0]    e_waddr;
    logic [31:0]   e_wdata, e_mask;
    logic [CW-1:0] e_count;

    wb_port_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_predict();
        bit empty;
        empty   = (mq.size() == 0);
        e_hold  = !empty && (mwait >= MAXW);
        e_grant = bus.w_we && !e_hold;
        e_ready = (mq.size() < DEPTH);
        e_count = CW'(mq.size());
        e_mask  = 32'd0;
        foreach (mq[i]) if (mq[i].vld) e_mask[mq[i].dest] = 1'b1;
        e_mask[0] = 1'b0;
        e_rf_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
        if (!rst) begin
            if (e_grant) begin
                e_rf_we = 1'b1; e_waddr = bus.w_dest; e_wdata = bus.w_data;
            end else if (!empty && mq[0].vld) begin
                e_rf_we = 1'b1; e_waddr = mq[0].dest; e_wdata = mq[0].data;
            end
        end
    endfunction

    function automatic void model_update();
        bit empty, head_v, popped;
        int nw;
        ent_t e;
        model_predict();
        if (rst) begin
            mq.delete();
            mwait = 0;
            return;
        end
        empty  = (mq.size() == 0);
        head_v = !empty && mq[0].vld;
        popped = !empty && (!mq[0].vld || !e_grant);
        if (empty || (head_v && popped)) nw = 0;
        else if (head_v && e_grant)      nw = (mwait < MAXW) ? mwait + 1 : MAXW;
        else                             nw = mwait;
        if (e_grant && bus.w_dest != 0)
            foreach (mq[i]) if (mq[i].dest == bus.w_dest) mq[i].vld = 1'b0;
        if (popped) void'(mq.pop_front());
        if (bus.ll_valid && e_ready) begin
            e.vld  = (bus.ll_dest != 0) && !(e_grant && bus.w_dest != 0 && bus.ll_dest == bus.w_dest);
            e.dest = bus.ll_dest;
            e.data = bus.ll_data;
            mq.push_back(e);
        end
        if (bus.ll_flush) begin
            mq.delete();
            nw = 0;
        end
        mwait = nw;
    endfunction

    task automatic tick();
        model_update();
        if (!rst && bus.rf_we) rf_shadow[bus.rf_waddr] = bus.rf_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                         input logic fl);
        bus.w_we = we; bus.w_dest = wd; bus.w_data = wdat;
        bus.ll_valid = lv; bus.ll_dest = ld; bus.ll_data = ldat; bus.ll_flush = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, 1'b0);
        n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got=%0b exp=0", bus.rf_we); end
        tick(); tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL idle_rf_we c%0d got=%0b exp=0", k, bus.rf_we); end
            n_vec++; if (bus.ll_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready c%0d got=%0b exp=1", k, bus.ll_ready); end
            n_vec++; if (bus.ll_pend_mask !== 32'd0) begin n_err++; $display("FAIL idle_mask c%0d got=%h exp=0", k, bus.ll_pend_mask); end
            n_vec++; if (bus.fifo_count !== CW'(0)) begin n_err++; $display("FAIL idle_count c%0d got=%0d exp=0", k, bus.fifo_count); end
            n_vec++; if (bus.w_hold !== 1'b0) begin n_err++; $display("FAIL idle_hold c%0d got=%0b exp=0", k, bus.w_hold); end
            tick();
        end
    endtask

    task automatic test_drain();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 1'b0);
        n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL drain_pre_we got=%0b exp=0", bus.rf_we); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h11}) begin
            n_err++; $display("FAIL drain_write got=%0b/%0d/%h exp=1/5/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_vec++; if (bus.ll_pend_mask !== 32'h20) begin n_err++; $display("FAIL drain_mask got=%h exp=20", bus.ll_pend_mask); end
        n_vec++; if (bus.fifo_count !== CW'(1)) begin n_err++; $display("FAIL drain_count1 got=%0d exp=1", bus.fifo_count); end
        tick();
        n_vec++; if (bus.ll_pend_mask !== 32'd0) begin n_err++; $display("FAIL drain_mask_clr got=%h exp=0", bus.ll_pend_mask); end
        n_vec++; if (bus.fifo_count !== CW'(0)) begin n_err++; $display("FAIL drain_count0 got=%0d exp=0", bus.fifo_count); end
        n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL drain_post_we got=%0b exp=0", bus.rf_we); end
    endtask

    task automatic test_starvation();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAA, 1'b0);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            n_vec++; if ({bus.w_hold, bus.rf_we, bus.rf_waddr} !== {1'b0, 1'b1, 5'd3}) begin
                n_err++; $display("FAIL starve_w_wins c%0d got=%0b/%0b/%0d exp=0/1/3", k, bus.w_hold, bus.rf_we, bus.rf_waddr); end
            tick();
        end
        n_vec++; if ({bus.w_hold, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'hAA}) begin
            n_err++; $display("FAIL starve_hold got=%0b/%0b/%0d/%h exp=1/1/7/aa", bus.w_hold, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        n_vec++; if ({bus.w_hold, bus.rf_waddr, bus.fifo_count} !== {1'b0, 5'd3, CW'(0)}) begin
            n_err++; $display("FAIL starve_resume got=%0b/%0d/%0d exp=0/3/0", bus.w_hold, bus.rf_waddr, bus.fifo_count); end
        tick();
    endtask

    task automatic test_kill();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (bus.ll_pend_mask !== 32'h200) begin n_err++; $display("FAIL kill_mask_set got=%h exp=200", bus.ll_pend_mask); end
        n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd9, 32'h2}) begin
            n_err++; $display("FAIL kill_w_write got=%0b/%0d/%h exp=1/9/2", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if ({bus.ll_pend_mask, bus.fifo_count, bus.rf_we} !== {32'd0, CW'(1), 1'b0}) begin
            n_err++; $display("FAIL kill_silent_pop got=%h/%0d/%0b exp=0/1/0", bus.ll_pend_mask, bus.fifo_count, bus.rf_we); end
        tick();
        n_vec++; if (bus.fifo_count !== CW'(0)) begin n_err++; $display("FAIL kill_count got=%0d exp=0", bus.fifo_count); end
        tick();
        n_vec++; if (rf_shadow[9] !== 32'h2) begin n_err++; $display("FAIL kill_rf9 got=%h exp=2", rf_shadow[9]); end
    endtask

    task automatic test_full_flush();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0, 1'b0); tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB0, 1'b0);
        n_vec++; if ({bus.fifo_count, bus.ll_ready} !== {CW'(1), 1'b1}) begin
            n_err++; $display("FAIL full_b got=%0d/%0b exp=1/1", bus.fifo_count, bus.ll_ready); end
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC0, 1'b0);
        n_vec++; if ({bus.fifo_count, bus.ll_ready} !== {CW'(2), 1'b0}) begin
            n_err++; $display("FAIL full_c got=%0d/%0b exp=2/0", bus.fifo_count, bus.ll_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 1'b0);
        n_vec++; if ({bus.fifo_count, bus.ll_ready, bus.rf_we, bus.rf_waddr} !== {CW'(2), 1'b0, 1'b1, 5'd10}) begin
            n_err++; $display("FAIL full_d got=%0d/%0b/%0b/%0d exp=2/0/1/10", bus.fifo_count, bus.ll_ready, bus.rf_we, bus.rf_waddr); end
        tick();
        n_vec++; if ({bus.fifo_count, bus.ll_ready, bus.rf_waddr} !== {CW'(1), 1'b1, 5'd11}) begin
            n_err++; $display("FAIL full_e got=%0d/%0b/%0d exp=1/1/11", bus.fifo_count, bus.ll_ready, bus.rf_waddr); end
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b1);
        n_vec++; if ({bus.fifo_count, bus.ll_pend_mask} !== {CW'(1), 32'h1000}) begin
            n_err++; $display("FAIL full_f got=%0d/%h exp=1/1000", bus.fifo_count, bus.ll_pend_mask); end
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_vec++; if ({bus.fifo_count, bus.ll_pend_mask, bus.rf_we} !== {CW'(0), 32'd0, 1'b0}) begin
                n_err++; $display("FAIL flush_after c%0d got=%0d/%h/%0b exp=0/0/0", k, bus.fifo_count, bus.ll_pend_mask, bus.rf_we); end
            tick();
        end
    endtask

    task automatic test_dest_zero();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if ({bus.fifo_count, bus.ll_pend_mask, bus.rf_we} !== {CW'(1), 32'd0, 1'b0}) begin
            n_err++; $display("FAIL zero_dest got=%0d/%h/%0b exp=1/0/0", bus.fifo_count, bus.ll_pend_mask, bus.rf_we); end
        tick();
        n_vec++; if (bus.fifo_count !== CW'(0)) begin n_err++; $display("FAIL zero_pop got=%0d exp=0", bus.fifo_count); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_we got=%0b exp=0", bus.rf_we); end
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if ({bus.fifo_count, bus.rf_we} !== {CW'(0), 1'b0}) begin
            n_err++; $display("FAIL midrst_after got=%0d/%0b exp=0/0", bus.fifo_count, bus.rf_we); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 39) == 0);
            model_predict();
            n_vec++; if (bus.rf_we !== e_rf_we) begin n_err++; $display("FAIL rand_rf_we n=%0d got=%0b exp=%0b", n, bus.rf_we, e_rf_we); end
            n_vec++; if (bus.rf_waddr !== e_waddr) begin n_err++; $display("FAIL rand_waddr n=%0d got=%0d exp=%0d", n, bus.rf_waddr, e_waddr); end
            n_vec++; if (bus.rf_wdata !== e_wdata) begin n_err++; $display("FAIL rand_wdata n=%0d got=%h exp=%h", n, bus.rf_wdata, e_wdata); end
            n_vec++; if (bus.w_hold !== e_hold) begin n_err++; $display("FAIL rand_hold n=%0d got=%0b exp=%0b", n, bus.w_hold, e_hold); end
            n_vec++; if (bus.ll_ready !== e_ready) begin n_err++; $display("FAIL rand_ready n=%0d got=%0b exp=%0b", n, bus.ll_ready, e_ready); end
            n_vec++; if (bus.ll_pend_mask !== e_mask) begin n_err++; $display("FAIL rand_mask n=%0d got=%h exp=%h", n, bus.ll_pend_mask, e_mask); end
            n_vec++; if (bus.fifo_count !== e_count) begin n_err++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, bus.fifo_count, e_count); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        mwait = 0;
        for (int r = 0; r < 32; r++) rf_shadow[r] = 32'd0;
        bus.w_we = 1'b0; bus.w_dest = 5'd0; bus.w_data = 32'd0;
        bus.ll_valid = 1'b0; bus.ll_dest = 5'd0; bus.ll_data = 32'd0; bus.ll_flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_drain();
        test_starvation();
        test_kill();
        test_full_flush();
        test_dest_zero();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
